// File: rtl/sdio_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : sdio_sram_arb
// Brief    : Round-robin arbiter that gives one shared asynchronous SRAM to an
//            SDIO function-1 requester and a local CPU requester.
// Revision : 1.0
// ============================================================================
module sdio_sram_arb #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        sram_clk,
  input  logic        sram_resetn,
  input  logic [2:0]  cmd52_53_func_num,
  input  logic        io_en_func1,
  input  logic        sdio_req,
  input  logic        sdio_we,
  input  logic [16:0] sdio_addr,
  input  logic [7:0]  sdio_wdata,
  output logic        sdio_ack,
  output logic [7:0]  sdio_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [16:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        sram_en,
  output logic        sram_csn,
  output logic        sram_wen,
  output logic        sram_oen,
  output logic [16:0] sram_addr,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("sdio_sram_arb: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [3:0] c_last_cnt = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_owner_cpu;
  logic        r_last_cpu;

  logic        w_sdio_valid;
  logic        w_any_valid;
  logic        w_grant_cpu;

  assign w_sdio_valid = sdio_req && (cmd52_53_func_num == 3'b001) && io_en_func1;
  assign w_any_valid  = w_sdio_valid || cpu_req;
  // On a tie the requester that did not own the previous access wins.
  assign w_grant_cpu  = cpu_req && (!w_sdio_valid || !r_last_cpu);

  always_ff @(posedge sram_clk or negedge sram_resetn) begin
    if (!sram_resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_owner_cpu <= 1'b0;
      r_last_cpu  <= 1'b1;
      sram_csn    <= 1'b1;
      sram_wen    <= 1'b1;
      sram_oen    <= 1'b1;
      sram_addr   <= 17'd0;
      sram_dout   <= 8'd0;
      sdio_ack    <= 1'b0;
      cpu_ack     <= 1'b0;
      sdio_rdata  <= 8'd0;
      cpu_rdata   <= 8'd0;
    end else begin
      sdio_ack <= 1'b0;
      cpu_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sram_en && w_any_valid) begin
            r_state     <= S_SETUP;
            r_owner_cpu <= w_grant_cpu;
            r_last_cpu  <= w_grant_cpu;
            r_we        <= w_grant_cpu ? cpu_we    : sdio_we;
            sram_addr   <= w_grant_cpu ? cpu_addr  : sdio_addr;
            sram_dout   <= w_grant_cpu ? cpu_wdata : sdio_wdata;
            sram_csn    <= 1'b0;
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
          r_cnt   <= 4'd0;
          if (r_we) sram_wen <= 1'b0;
          else      sram_oen <= 1'b0;
        end
        S_ACCESS: begin
          if (r_cnt == c_last_cnt) begin
            r_state  <= S_HOLD;
            r_cnt    <= 4'd0;
            sram_wen <= 1'b1;
            sram_oen <= 1'b1;
            // Read data is captured while OE is still asserted.
            if (!r_we) begin
              if (r_owner_cpu) cpu_rdata  <= sram_din;
              else             sdio_rdata <= sram_din;
            end
            if (r_owner_cpu) cpu_ack  <= 1'b1;
            else             sdio_ack <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HOLD: begin
          r_state  <= S_IDLE;
          sram_csn <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sdio_sram_arb.md
SDIO_SRAM_ARB -- requirements
Module: sdio_sram_arb

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of ACCESS-state cycles per SRAM cycle; the legal range is 1..15.
REQ-002 sram_clk  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-003 sram_resetn  in  1  SHALL be the reset, asynchronous and active-low.
REQ-004 cmd52_53_func_num  in  3  SHALL be the function number of the current CMD52/53.
REQ-005 io_en_func1  in  1  SHALL be the function-1 I/O enable from the CCCR.
REQ-006 sdio_req, sdio_we  in  1 each  SHALL be the SDIO-side access request and write flag.
REQ-007 sdio_addr  in  17  SHALL be the SDIO-side address; sdio_wdata  in  8  SHALL be its write data.
REQ-008 sdio_ack  out  1  SHALL be a one-cycle completion pulse; sdio_rdata  out  8  SHALL be the SDIO-side read data.
REQ-009 cpu_req, cpu_we, cpu_addr[16:0], cpu_wdata[7:0], cpu_ack, cpu_rdata[7:0] SHALL be the local-CPU requester port, with the same meanings as the SDIO-side ports.
REQ-010 sram_en  in  1  SHALL be the global SRAM enable; when low, no new grants are issued.
REQ-011 sram_csn, sram_wen, sram_oen  out  1 each  SHALL be the active-low SRAM strobes.
REQ-012 sram_addr  out  17 and sram_dout  out  8  SHALL carry the address and write data to the SRAM; sram_din  in  8  SHALL carry read data from the SRAM.

Function
REQ-013 The SDIO request SHALL be valid only when sdio_req=1, cmd52_53_func_num==3'b001 and io_en_func1=1; otherwise the SDIO request SHALL be ignored.
REQ-014 The FSM SHALL have the states IDLE, SETUP, ACCESS and HOLD.
REQ-015 IDLE: when sram_en=1 and at least one valid request is present, the FSM SHALL grant one requester, latch its addr/we/wdata and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin on a last_owner register; when both requesters are valid, the requester that is not last_owner SHALL win.
REQ-017 SETUP SHALL last 1 cycle with csn=0, wen=1, oen=1 and address/data driven.
REQ-018 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter, with csn=0 and wen=0 for a write or oen=0 for a read.
REQ-019 On the last ACCESS cycle of a read, the block SHALL register sram_din into the owner's rdata.
REQ-020 HOLD SHALL last 1 cycle with csn=0, wen=1, oen=1; the owner's ack SHALL be 1 in HOLD only; the FSM SHALL return to IDLE.
REQ-021 sram_addr and sram_dout SHALL remain stable from SETUP through HOLD.
REQ-022 Latency SHALL be WAIT_CYCLES+2 cycles from the grant edge to ack; there SHALL be at least 1 IDLE cycle with csn=1 between consecutive accesses.
REQ-023 Each requester SHALL hold req and its operands until ack; if req is still high in the cycle after ack, the block SHALL treat it as a new request.
REQ-024 A requester's rdata SHALL hold its last read value until that requester's next read completes.
REQ-025 Requester inputs that change after the grant SHALL NOT affect the access in flight.
REQ-026 If sram_en is deasserted mid-access, the access in flight SHALL complete normally; if sram_en is low in IDLE, no grant SHALL be issued.
REQ-027 If the function number or io_en_func1 changes after an SDIO grant, the access in flight SHALL complete.
REQ-028 Only one ack SHALL ever be high in a given cycle.

Reset
REQ-029 While sram_resetn=0, the block SHALL hold: state=IDLE, sram_csn=sram_wen=sram_oen=1, sram_addr=0, sram_dout=0, both acks=0, both rdata=0, counter=0, last_owner=CPU (so SDIO wins the first tie).
REQ-030 Reset asserted mid-access SHALL force the strobes high asynchronously; the aborted access SHALL produce no ack.
REQ-031 After sram_resetn rises, the first grant SHALL occur no earlier than the first rising edge of sram_clk.

Verification
REQ-032 With WAIT_CYCLES=2, a SDIO write (func 1, io_en=1, addr 0x1ABCD, data 0x5A) SHALL give csn low for 4 cycles, wen low for cycles 2-3, and sdio_ack in cycle 4; the SRAM model SHALL then hold 0x5A at 0x1ABCD.
REQ-033 A CPU read of addr 0x00010 with the model holding 0xC3 SHALL give oen low for 2 cycles, then cpu_ack with cpu_rdata=0xC3.
REQ-034 With both requesters held continuously after reset, grants SHALL alternate SDIO, CPU, SDIO, CPU, with a csn-high gap between each.
REQ-035 A SDIO request with func_num=3'b010, or with io_en_func1=0, SHALL give no grant and csn staying 1 for 20 cycles.
REQ-036 Reset pulsed during the ACCESS state SHALL give strobes high in the same cycle, no ack, and IDLE after release.
REQ-037 With sram_en=0 and both requesters pending, no grant SHALL occur; raising sram_en SHALL give a grant to SDIO within 1 cycle.
